// File: rtl/hamming_pkg.sv
// ============================================================================
// Module   : hamming_pkg
// Purpose  : Shared SECDED Hamming parameters, position helpers and the
//            serial decoder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

  // Number of Hamming parity bits, not counting the overall parity bit.
  localparam int R = 4;
  // Extended codeword length: position 0 carries the overall parity.
  localparam int N = 1 << R;
  // Payload bits per codeword.
  localparam int K = N - R - 1;

  // Index of the final codeword position, in the width of the position counter.
  localparam logic [R-1:0] LAST_POS = R'(N - 1);

  // Serial decoder control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for the Hamming parity positions 1, 2, 4, 8, ...
  // Position 0 is the overall parity bit and is not treated as a power of two.
  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Maps a data-carrying codeword position to its payload bit index.
  // Payload bits occupy the non-power-of-two positions in ascending order,
  // so position 3 is payload bit 0 and position N-1 is payload bit K-1.
  function automatic int data_index(input int pos);
    int j;
    j = 0;
    for (int p = 1; p < pos; p++) begin
      if (!is_pow2(p)) begin
        j++;
      end
    end
    return j;
  endfunction

endpackage : hamming_pkg

`default_nettype wire

// File: rtl/hamming_decoder_if.sv
// ============================================================================
// Module   : hamming_decoder_if
// Purpose  : Serial codeword input and parallel payload output bundle of the
//            serial SECDED decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hamming_decoder_if;
  import hamming_pkg::*;

  // Serial receive side
  logic         datain;
  logic         in_valid;
  logic         sof;

  // Parallel payload side
  logic [K-1:0] dataout;
  logic         out_valid;
  logic         err_corr;
  logic         err_dbl;
  logic         busy;

  // Channel / bench side: drives the serial bits, consumes the payload.
  modport master (
    output datain,
    output in_valid,
    output sof,
    input  dataout,
    input  out_valid,
    input  err_corr,
    input  err_dbl,
    input  busy
  );

  // Decoder side.
  modport slave (
    input  datain,
    input  in_valid,
    input  sof,
    output dataout,
    output out_valid,
    output err_corr,
    output err_dbl,
    output busy
  );

endinterface : hamming_decoder_if

`default_nettype wire

// File: rtl/hamming_extract.sv
// ============================================================================
// Module   : hamming_extract
// Purpose  : Combinational payload extraction: gathers the K data bits from
//            the non-power-of-two positions of an N-bit codeword.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_extract
  import hamming_pkg::*;
(
  input  wire logic [N-1:0] cw,
  output logic      [K-1:0] data
);

  // Parity positions carry no payload; they are gathered here only so the
  // whole codeword bus is visibly consumed.
  logic w_unused_cw;
  assign w_unused_cw = ^cw;

  genvar p;
  generate
    for (p = 1; p < N; p++) begin : g_pos
      if (!is_pow2(p)) begin : g_data
        assign data[data_index(p)] = cw[p];
      end
    end
  endgenerate

endmodule : hamming_extract

`default_nettype wire

// File: rtl/hamming_decoder.sv
// ============================================================================
// Module   : hamming_decoder
// Purpose  : Serial-in SECDED extended-Hamming decoder. Collects one N-bit
//            codeword bit-serially (position 0 first), accumulates syndrome
//            and overall parity on the fly, then corrects single errors,
//            flags double errors and presents the K payload bits in parallel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_decoder
  import hamming_pkg::*;
(
  input wire logic         clk,
  input wire logic         rst_n,
  hamming_decoder_if.slave bus
);

  // Receive state
  state_t         r_state;
  logic [R-1:0]   r_pos;       // position of the next expected bit
  logic [R-1:0]   r_syn;       // XOR of the positions of all received ones
  logic           r_par;       // XOR of all received bits, position 0 included
  logic [N-1:0]   r_cw;        // received codeword, bit i = position i

  // Registered outputs
  logic [K-1:0]   r_dataout;
  logic           r_out_valid;
  logic           r_err_corr;
  logic           r_err_dbl;
  logic           r_busy;

  // Correction path
  logic           w_sof_bit;
  logic [N-1:0]   w_flip;
  logic [N-1:0]   w_cw_fix;
  logic [K-1:0]   w_data;

  // A start-of-frame bit is honoured in every state: it opens a frame from
  // IDLE, aborts a partial frame in RECV, and chains frames from DONE.
  assign w_sof_bit = bus.in_valid & bus.sof;

  // With odd overall parity the syndrome names the single bad position;
  // syndrome 0 means the overall parity bit itself was hit. Even parity
  // with a non-zero syndrome is a double error and must not be touched.
  assign w_flip   = r_par ? (N'(1) << r_syn) : '0;
  assign w_cw_fix = r_cw ^ w_flip;

  hamming_extract u_extract (
    .cw   (w_cw_fix),
    .data (w_data)
  );

  // Frame FSM, syndrome/parity accumulation and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pos       <= '0;
      r_syn       <= '0;
      r_par       <= 1'b0;
      r_cw        <= '0;
      r_dataout   <= '0;
      r_out_valid <= 1'b0;
      r_err_corr  <= 1'b0;
      r_err_dbl   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;

      // Result of the frame that just completed; uses the pre-update
      // accumulators, so a chained sof in the same cycle is harmless.
      if (r_state == ST_DONE) begin
        r_out_valid <= 1'b1;
        r_dataout   <= w_data;
        r_err_corr  <= r_par;
        r_err_dbl   <= ~r_par & (r_syn != '0);
      end

      if (w_sof_bit) begin
        // Position 0 contributes nothing to the syndrome, only to parity.
        r_state <= ST_RECV;
        r_pos   <= R'(1);
        r_syn   <= '0;
        r_par   <= bus.datain;
        r_cw    <= N'(bus.datain);
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            // Bits outside a frame are dropped until the next sof.
            r_state <= ST_IDLE;
          end

          ST_RECV: begin
            if (bus.in_valid) begin
              r_cw[r_pos] <= bus.datain;
              r_syn       <= r_syn ^ (bus.datain ? r_pos : '0);
              r_par       <= r_par ^ bus.datain;
              if (r_pos == LAST_POS) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
              end else begin
                r_pos <= r_pos + 1'b1;
              end
            end
          end

          ST_DONE: begin
            r_state <= ST_IDLE;
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dataout   = r_dataout;
  assign bus.out_valid = r_out_valid;
  assign bus.err_corr  = r_err_corr;
  assign bus.err_dbl   = r_err_dbl;
  assign bus.busy      = r_busy;

endmodule : hamming_decoder

`default_nettype wire

// File: tb/tb_hamming_decoder.sv
// ============================================================================
// Module   : tb_hamming_decoder
// Purpose  : Directed self-checking bench for the serial SECDED decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_decoder;

  localparam int NB = 16;
  localparam int KB = 11;

  typedef struct {
    logic [KB-1:0] data;
    logic          corr;
    logic          dbl;
    int            cyc;
  } res_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   cyc;
  int   sof_cyc;
  res_t q[$];

  hamming_decoder_if bus ();

  hamming_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: counts edges, notes sof edges, records every out_valid.
  initial begin
    res_t r;
    cyc     = 0;
    sof_cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (bus.in_valid === 1'b1 && bus.sof === 1'b1 && rst_n === 1'b1) sof_cyc = cyc;
      #1;
      if (bus.out_valid === 1'b1) begin
        r.data = bus.dataout;
        r.corr = bus.err_corr;
        r.dbl  = bus.err_dbl;
        r.cyc  = cyc;
        q.push_back(r);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference encoder: payload at non-power-of-two positions,
  // Hamming parity at 1,2,4,8, overall parity at 0.
  function automatic logic [NB-1:0] encode(input logic [KB-1:0] d);
    logic [NB-1:0] c;
    logic [3:0]    s;
    int            j;
    c = '0;
    j = 0;
    for (int p = 1; p < NB; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    s = '0;
    for (int p = 1; p < NB; p++) if (c[p]) s = s ^ 4'(p);
    for (int i = 0; i < 4; i++) c[1 << i] = s[i];
    c[0] = ^c[NB-1:1];
    return c;
  endfunction

  task automatic put(input logic b, input logic v, input logic s);
    @(negedge clk);
    bus.datain   = b;
    bus.in_valid = v;
    bus.sof      = s;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [NB-1:0] cw);
    for (int i = 0; i < NB; i++) put(cw[i], 1'b1, (i == 0));
  endtask

  // Bounded wait for the next recorded result; an expired bound is a failure.
  task automatic wait_out(input string name, output bit ok, output res_t r);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (q.size() > 0) break;
      @(negedge clk);
    end
    if (q.size() > 0) begin
      r  = q.pop_front();
      ok = 1'b1;
    end else begin
      n_total++;
      $display("FAIL %s: no out_valid within 40 cycles", name);
    end
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    bus.datain   = 1'b0;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({bus.dataout, bus.out_valid, bus.err_corr, bus.err_dbl, bus.busy} !== '0)
      $display("FAIL reset_state: got data=%h ov=%b corr=%b dbl=%b busy=%b, expected all 0",
               bus.dataout, bus.out_valid, bus.err_corr, bus.err_dbl, bus.busy);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_clean;
    logic [NB-1:0] cw;
    res_t r;
    bit   ok;
    cw = 16'h000F;
    for (int i = 0; i < NB; i++) begin
      put(cw[i], 1'b1, (i == 0));
      if (i == 5) begin
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL clean_busy: got %b, expected 1", bus.busy);
        else n_pass++;
      end
    end
    idle(1);
    wait_out("clean", ok, r);
    if (ok) begin
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {11'h001, 1'b0, 1'b0})
        $display("FAIL clean_result: got data=%h corr=%b dbl=%b, expected data=001 corr=0 dbl=0",
                 r.data, r.corr, r.dbl);
      else n_pass++;
      n_total++;
      if (r.cyc - sof_cyc !== 16)
        $display("FAIL clean_latency: got %0d edges after sof, expected 16", r.cyc - sof_cyc);
      else n_pass++;
    end
    idle(4);
    n_total++;
    if (q.size() !== 0 || bus.busy !== 1'b0)
      $display("FAIL clean_pulse: got %0d extra pulses busy=%b, expected 0 and 0", q.size(), bus.busy);
    else n_pass++;
  endtask

  task automatic test_single;
    res_t r;
    bit   ok;
    send(16'h0007);
    idle(1);
    wait_out("single", ok, r);
    if (ok) begin
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {11'h001, 1'b1, 1'b0})
        $display("FAIL single_result: got data=%h corr=%b dbl=%b, expected data=001 corr=1 dbl=0",
                 r.data, r.corr, r.dbl);
      else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_overall_parity;
    res_t r;
    bit   ok;
    send(16'h0001);
    idle(1);
    wait_out("overall", ok, r);
    if (ok) begin
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {11'h000, 1'b1, 1'b0})
        $display("FAIL overall_result: got data=%h corr=%b dbl=%b, expected data=000 corr=1 dbl=0",
                 r.data, r.corr, r.dbl);
      else n_pass++;
    end
    idle(2);
  endtask

  task automatic test_double;
    res_t r;
    bit   ok;
    send(16'h0060);
    idle(1);
    wait_out("double", ok, r);
    if (ok) begin
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {11'h006, 1'b0, 1'b1})
        $display("FAIL double_result: got data=%h corr=%b dbl=%b, expected data=006 corr=0 dbl=1",
                 r.data, r.corr, r.dbl);
      else n_pass++;
    end
    idle(3);
    n_total++;
    if ({bus.dataout, bus.err_corr, bus.err_dbl} !== {11'h006, 1'b0, 1'b1})
      $display("FAIL double_hold: got data=%h corr=%b dbl=%b, expected data=006 corr=0 dbl=1",
               bus.dataout, bus.err_corr, bus.err_dbl);
    else n_pass++;
  endtask

  task automatic test_framing;
    logic [NB-1:0] cw;
    logic [NB-1:0] cw2;
    res_t r;
    res_t r2;
    bit   ok;
    // Stray bits with no sof are ignored.
    repeat (3) put(1'b1, 1'b1, 1'b0);
    idle(3);
    n_total++;
    if (q.size() !== 0 || bus.busy !== 1'b0)
      $display("FAIL frame_drop: got pulses=%0d busy=%b, expected 0 and 0", q.size(), bus.busy);
    else n_pass++;

    // Frame with in_valid gaps.
    cw = 16'h000F;
    for (int i = 0; i < NB; i++) begin
      put(cw[i], 1'b1, (i == 0));
      if (i % 3 == 1) idle(2);
    end
    idle(1);
    wait_out("gaps", ok, r);
    if (ok) begin
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {11'h001, 1'b0, 1'b0})
        $display("FAIL gaps_result: got data=%h corr=%b dbl=%b, expected data=001 corr=0 dbl=0",
                 r.data, r.corr, r.dbl);
      else n_pass++;
    end
    idle(2);

    // Abort at position 9 and restart with a different word.
    cw = encode(11'h7FF);
    for (int i = 0; i < 9; i++) put(cw[i], 1'b1, (i == 0));
    send(encode(11'h555));
    idle(20);
    n_total++;
    if (q.size() !== 1) $display("FAIL abort_count: got %0d results, expected 1", q.size());
    else n_pass++;
    if (q.size() > 0) begin
      r = q.pop_front();
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {11'h555, 1'b0, 1'b0})
        $display("FAIL abort_result: got data=%h corr=%b dbl=%b, expected data=555 corr=0 dbl=0",
                 r.data, r.corr, r.dbl);
      else n_pass++;
    end
    q.delete();

    // Back-to-back frames, second one with a flipped data bit at position 7.
    cw2 = encode(11'h456);
    cw2[7] = ~cw2[7];
    send(encode(11'h123));
    send(cw2);
    idle(20);
    n_total++;
    if (q.size() !== 2) $display("FAIL b2b_count: got %0d results, expected 2", q.size());
    else n_pass++;
    if (q.size() >= 2) begin
      r  = q.pop_front();
      r2 = q.pop_front();
      n_total++;
      if ({r.data, r.corr, r.dbl, r2.data, r2.corr, r2.dbl} !==
          {11'h123, 1'b0, 1'b0, 11'h456, 1'b1, 1'b0})
        $display("FAIL b2b_result: got %h/%b/%b %h/%b/%b, expected 123/0/0 456/1/0",
                 r.data, r.corr, r.dbl, r2.data, r2.corr, r2.dbl);
      else n_pass++;
      n_total++;
      if (r2.cyc - r.cyc !== 16)
        $display("FAIL b2b_spacing: got %0d cycles apart, expected 16", r2.cyc - r.cyc);
      else n_pass++;
    end
    q.delete();
  endtask

  task automatic test_reset_midframe;
    logic [NB-1:0] cw;
    res_t r;
    bit   ok;
    cw = encode(11'h3AB);
    for (int i = 0; i < 10; i++) put(cw[i], 1'b1, (i == 0));
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.dataout, bus.out_valid, bus.err_corr, bus.err_dbl, bus.busy} !== '0)
      $display("FAIL async_reset: got data=%h ov=%b corr=%b dbl=%b busy=%b, expected all 0",
               bus.dataout, bus.out_valid, bus.err_corr, bus.err_dbl, bus.busy);
    else n_pass++;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    n_total++;
    if (q.size() !== 0) $display("FAIL reset_discard: got %0d results, expected 0", q.size());
    else n_pass++;
    q.delete();
    send(encode(11'h2C5));
    idle(1);
    wait_out("after_reset", ok, r);
    if (ok) begin
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {11'h2C5, 1'b0, 1'b0})
        $display("FAIL after_reset_result: got data=%h corr=%b dbl=%b, expected data=2c5 corr=0 dbl=0",
                 r.data, r.corr, r.dbl);
      else n_pass++;
    end
    idle(2);
  endtask

  // Every payload word once, cycling through the 16 single-flip positions
  // and the error-free case, streamed back-to-back.
  task automatic test_sweep;
    res_t exp_q[$];
    res_t e;
    res_t r;
    logic [NB-1:0] cw;
    int   f;
    int   bad;
    bad = 0;
    q.delete();
    for (int w = 0; w < (1 << KB); w++) begin
      cw = encode(KB'(w));
      f  = w % 17;
      if (f < NB) cw[f] = ~cw[f];
      e.data = KB'(w);
      e.corr = (f < NB);
      e.dbl  = 1'b0;
      e.cyc  = 0;
      exp_q.push_back(e);
      send(cw);
      while (q.size() > 0 && exp_q.size() > 0) begin
        r = q.pop_front();
        e = exp_q.pop_front();
        n_total++;
        if ({r.data, r.corr, r.dbl} !== {e.data, e.corr, e.dbl}) begin
          if (bad < 10)
            $display("FAIL sweep_word: got data=%h corr=%b dbl=%b, expected data=%h corr=%b dbl=%b",
                     r.data, r.corr, r.dbl, e.data, e.corr, e.dbl);
          bad++;
        end else n_pass++;
      end
    end
    idle(20);
    while (q.size() > 0 && exp_q.size() > 0) begin
      r = q.pop_front();
      e = exp_q.pop_front();
      n_total++;
      if ({r.data, r.corr, r.dbl} !== {e.data, e.corr, e.dbl})
        $display("FAIL sweep_tail: got data=%h corr=%b dbl=%b, expected data=%h corr=%b dbl=%b",
                 r.data, r.corr, r.dbl, e.data, e.corr, e.dbl);
      else n_pass++;
    end
    n_total++;
    if (q.size() !== 0 || exp_q.size() !== 0)
      $display("FAIL sweep_count: got %0d unexpected and %0d missing results, expected 0 and 0",
               q.size(), exp_q.size());
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_clean();
    test_single();
    test_overall_parity();
    test_double();
    test_framing();
    test_reset_midframe();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_hamming_decoder

`default_nettype wire
